// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: state encodings,
// default constants and the word-alignment helper.
package if_fetch_unit_pkg;

    typedef logic [31:0] word_t;

    // FSM encodings, kept numerically identical to the legacy header values
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam word_t RESET_PC_DEF  = 32'h0000_0000;
    localparam word_t NOP_INSTR_DEF = 32'h0000_0013;   // addi x0,x0,0

    // Redirect targets are word addresses; the low two bits are dropped
    function automatic word_t word_align(input word_t a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Bundle of the IF stage's control, instruction-memory and IF/ID signals.
// master = fetch unit, slave = surrounding pipeline / memory.
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;

    logic  BUBBLE;
    logic  BRANCH_TAKEN;
    word_t BRANCH_TARGET;
    word_t IMEM_READDATA;
    logic  IMEM_BUSYWAIT;
    logic  IMEM_READ;
    word_t IMEM_ADDR;
    word_t INSTRUCTION;
    word_t PC;
    word_t PC_PLUS_4;

    modport master (
        input  BUBBLE, BRANCH_TAKEN, BRANCH_TARGET, IMEM_READDATA, IMEM_BUSYWAIT,
        output IMEM_READ, IMEM_ADDR, INSTRUCTION, PC, PC_PLUS_4
    );

    modport slave (
        output BUBBLE, BRANCH_TAKEN, BRANCH_TARGET, IMEM_READDATA, IMEM_BUSYWAIT,
        input  IMEM_READ, IMEM_ADDR, INSTRUCTION, PC, PC_PLUS_4
    );

endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory, holds the
// fetched word for IF/ID, honours stalls and squashes wrong-path fetches.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter word_t RESET_PC  = RESET_PC_DEF,
    parameter word_t NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic CLK,
    input  logic RESET,
    if_fetch_unit_if.master bus
);

    logic [1:0] state_q, state_d;
    word_t      pc_q, pc_d;
    word_t      req_addr_q, req_addr_d;
    word_t      instr_buf_q, instr_buf_d;
    word_t      target;

    assign target = word_align(bus.BRANCH_TARGET);

    // Next-state / next-PC selection; redirect outranks stall outranks normal flow
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        instr_buf_d = instr_buf_q;
        if (bus.BRANCH_TAKEN)
            pc_d = target;
        case (state_q)
            S_IDLE: begin
                req_addr_d = pc_d;
                state_d    = S_FETCH;
            end
            S_FETCH: begin
                if (bus.BRANCH_TAKEN) begin
                    // An in-flight address must not move: wait it out in DRAIN
                    if (bus.IMEM_BUSYWAIT) begin
                        state_d = S_DRAIN;
                    end else begin
                        instr_buf_d = NOP_INSTR;
                        req_addr_d  = target;
                    end
                end else if (!bus.IMEM_BUSYWAIT) begin
                    instr_buf_d = bus.IMEM_READDATA;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.BRANCH_TAKEN) begin
                    instr_buf_d = NOP_INSTR;
                    req_addr_d  = target;
                    state_d     = S_FETCH;
                end else if (!bus.BUBBLE) begin
                    pc_d       = pc_q + 32'd4;
                    req_addr_d = pc_q + 32'd4;
                    state_d    = S_FETCH;
                end
            end
            default: begin // S_DRAIN: discard the wrong-path word, refetch from latest PC
                if (!bus.IMEM_BUSYWAIT) begin
                    req_addr_d = pc_d;
                    state_d    = S_FETCH;
                end
            end
        endcase
    end

    // State registers with synchronous reset; reset drops any pending access
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            instr_buf_q <= NOP_INSTR;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            instr_buf_q <= instr_buf_d;
        end
    end

    // Outputs decode registers only, so no input-to-output combinational path
    always_comb begin
        bus.IMEM_READ   = (state_q == S_FETCH) || (state_q == S_DRAIN);
        bus.IMEM_ADDR   = req_addr_q;
        bus.INSTRUCTION = (state_q == S_HOLD) ? instr_buf_q : NOP_INSTR;
        bus.PC          = pc_q;
        bus.PC_PLUS_4   = pc_q + 32'd4;
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus a random
// run, all compared against a flag-based behavioural fetch model.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst;
    int   vectors;
    int   errors;

    if_fetch_unit_if bus();

    if_fetch_unit #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .CLK  (clk),
        .RESET(rst),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    // The fetch unit is either just out of reset (idle), has a memory read
    // outstanding (reading, possibly for a squashed path), or is holding a word.
    logic        m_idle, m_reading, m_squash, m_held;
    logic [31:0] m_pc, m_addr, m_buf;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h00A0_0113;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F00;
    endfunction

    task automatic model_step(input logic r, input logic br, input logic [31:0] tgt,
                              input logic busy, input logic bub);
        logic [31:0] t;
        t = tgt & 32'hFFFF_FFFC;
        if (r) begin
            m_idle = 1; m_reading = 0; m_squash = 0; m_held = 0;
            m_pc = 0; m_addr = 0; m_buf = NOP;
        end else if (m_idle) begin
            if (br) m_pc = t;
            m_idle = 0; m_reading = 1; m_addr = m_pc;
        end else if (m_reading) begin
            if (br) m_pc = t;
            if (busy) begin
                if (br) m_squash = 1;
            end else if (m_squash || br) begin
                m_squash = 0; m_addr = m_pc;
            end else begin
                m_buf = mem_word(m_addr); m_held = 1; m_reading = 0;
            end
        end else if (m_held) begin
            if (br) begin
                m_pc = t; m_addr = m_pc; m_held = 0; m_reading = 1;
            end else if (!bub) begin
                m_pc = m_pc + 4; m_addr = m_pc; m_held = 0; m_reading = 1;
            end
        end
    endtask

    function automatic logic [128:0] exp_vec();
        return {m_reading, m_addr, (m_held ? m_buf : NOP), m_pc, m_pc + 32'd4};
    endfunction

    function automatic logic [128:0] obs_vec();
        return {bus.IMEM_READ, bus.IMEM_ADDR, bus.INSTRUCTION, bus.PC, bus.PC_PLUS_4};
    endfunction

    // One clock: drive inputs, step model at the edge, settle to negedge
    task automatic cycle(input logic r, input logic br, input logic [31:0] tgt,
                         input logic busy, input logic bub);
        rst                = r;
        bus.BRANCH_TAKEN   = br;
        bus.BRANCH_TARGET  = tgt;
        bus.IMEM_BUSYWAIT  = busy;
        bus.BUBBLE         = bub;
        bus.IMEM_READDATA  = busy ? $urandom : mem_word(m_addr);
        @(posedge clk);
        model_step(r, br, tgt, busy, bub);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        vectors++;
        if (obs_vec() !== {1'b0, 32'h0, NOP, 32'h0, 32'h4}) begin
            errors++; $display("FAIL reset_values: got %h want %h", obs_vec(), {1'b0, 32'h0, NOP, 32'h0, 32'h4});
        end
        cycle(0, 0, 0, 0, 0);
        vectors++;
        if (bus.IMEM_READ !== 1'b1 || bus.IMEM_ADDR !== 32'h0) begin
            errors++; $display("FAIL reset_first_read: got read=%b addr=%h want read=1 addr=0", bus.IMEM_READ, bus.IMEM_ADDR);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] ei [4];
        logic [31:0] ep [4];
        ei = '{NOP, 32'h0050_0093, NOP, 32'h00A0_0113};
        ep = '{32'h0, 32'h0, 32'h4, 32'h4};
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (bus.INSTRUCTION !== ei[i] || bus.PC !== ep[i] || obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL zero_wait[%0d]: got instr=%h pc=%h want instr=%h pc=%h", i, bus.INSTRUCTION, bus.PC, ei[i], ep[i]);
            end
            cycle(0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_wait_states();
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 1, 0);
            vectors++;
            if (bus.IMEM_READ !== 1'b1 || bus.IMEM_ADDR !== 32'h8 || bus.INSTRUCTION !== NOP || obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL wait_state[%0d]: got read=%b addr=%h instr=%h want read=1 addr=8 instr=%h", i, bus.IMEM_READ, bus.IMEM_ADDR, bus.INSTRUCTION, NOP);
            end
        end
        cycle(0, 0, 0, 0, 0);
        vectors++;
        if (bus.INSTRUCTION !== mem_word(32'h8) || bus.PC !== 32'h8 || bus.IMEM_READ !== 1'b0) begin
            errors++; $display("FAIL wait_data: got instr=%h pc=%h read=%b want instr=%h pc=8 read=0", bus.INSTRUCTION, bus.PC, bus.IMEM_READ, mem_word(32'h8));
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 0, 1);
            vectors++;
            if (bus.INSTRUCTION !== mem_word(32'h10) || bus.PC !== 32'h10 || bus.PC_PLUS_4 !== 32'h14 || bus.IMEM_READ !== 1'b0) begin
                errors++; $display("FAIL stall[%0d]: got instr=%h pc=%h pc4=%h read=%b want instr=%h pc=10 pc4=14 read=0", i, bus.INSTRUCTION, bus.PC, bus.PC_PLUS_4, bus.IMEM_READ, mem_word(32'h10));
            end
        end
        cycle(0, 0, 0, 0, 0);
        vectors++;
        if (bus.IMEM_READ !== 1'b1 || bus.IMEM_ADDR !== 32'h14 || bus.PC !== 32'h14) begin
            errors++; $display("FAIL stall_release: got read=%b addr=%h pc=%h want read=1 addr=14 pc=14", bus.IMEM_READ, bus.IMEM_ADDR, bus.PC);
        end
    endtask

    task automatic test_redirect_mid_access();
        cycle(0, 1, 32'h20, 0, 0);
        vectors++;
        if (bus.IMEM_ADDR !== 32'h20 || bus.PC !== 32'h20 || bus.IMEM_READ !== 1'b1) begin
            errors++; $display("FAIL redirect_setup: got addr=%h pc=%h want addr=20 pc=20", bus.IMEM_ADDR, bus.PC);
        end
        cycle(0, 1, 32'h103, 1, 0);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (bus.IMEM_ADDR !== 32'h20 || bus.IMEM_READ !== 1'b1 || bus.INSTRUCTION !== NOP || bus.PC !== 32'h100) begin
                errors++; $display("FAIL redirect_inflight[%0d]: got addr=%h read=%b instr=%h pc=%h want addr=20 read=1 instr=%h pc=100", i, bus.IMEM_ADDR, bus.IMEM_READ, bus.INSTRUCTION, bus.PC, NOP);
            end
            cycle(0, 0, 0, (i < 2), 0);
        end
        vectors++;
        if (bus.IMEM_ADDR !== 32'h100 || bus.IMEM_READ !== 1'b1 || bus.INSTRUCTION !== NOP) begin
            errors++; $display("FAIL redirect_refetch: got addr=%h read=%b instr=%h want addr=100 read=1 instr=%h", bus.IMEM_ADDR, bus.IMEM_READ, bus.INSTRUCTION, NOP);
        end
        cycle(0, 0, 0, 0, 0);
        vectors++;
        if (bus.INSTRUCTION !== mem_word(32'h100) || bus.PC !== 32'h100) begin
            errors++; $display("FAIL redirect_data: got instr=%h pc=%h want instr=%h pc=100", bus.INSTRUCTION, bus.PC, mem_word(32'h100));
        end
    endtask

    task automatic test_branch_bubble();
        cycle(0, 1, 32'h40, 0, 1);
        vectors++;
        if (bus.PC !== 32'h40 || bus.INSTRUCTION !== NOP || bus.IMEM_READ !== 1'b1 || bus.IMEM_ADDR !== 32'h40) begin
            errors++; $display("FAIL branch_bubble: got pc=%h instr=%h read=%b addr=%h want pc=40 instr=%h read=1 addr=40", bus.PC, bus.INSTRUCTION, bus.IMEM_READ, bus.IMEM_ADDR, NOP);
        end
    endtask

    task automatic test_wrap();
        cycle(0, 1, 32'hFFFF_FFFE, 0, 0);
        vectors++;
        if (bus.PC !== 32'hFFFF_FFFC || bus.PC_PLUS_4 !== 32'h0) begin
            errors++; $display("FAIL wrap_pc4: got pc=%h pc4=%h want pc=fffffffc pc4=0", bus.PC, bus.PC_PLUS_4);
        end
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        vectors++;
        if (bus.PC !== 32'h0 || bus.IMEM_ADDR !== 32'h0 || bus.IMEM_READ !== 1'b1) begin
            errors++; $display("FAIL wrap_advance: got pc=%h addr=%h read=%b want pc=0 addr=0 read=1", bus.PC, bus.IMEM_ADDR, bus.IMEM_READ);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(99) == 0), ($urandom_range(9) == 0), $urandom,
                  ($urandom_range(9) < 4), ($urandom_range(9) < 3));
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL random[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst = 1'b1;
        bus.BRANCH_TAKEN = 0; bus.BRANCH_TARGET = 0; bus.IMEM_BUSYWAIT = 0;
        bus.BUBBLE = 0; bus.IMEM_READDATA = 0;
        model_step(1, 0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_redirect_mid_access();
        test_branch_bubble();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
